// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-voted mid-bit sampling, optional parity,
// one or two stop bits, break detection and back-to-back frame support.
module uart_rx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic [DATA_BITS-1:0] rx_dat,
    output logic                 rx_ok,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int BCNT_W = 4;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    state_t               state, state_nxt;
    logic                 rx_m, rx_s, rx_d1, rx_d2;
    logic                 samp, fall, tick, last_data, last_stop;
    logic                 start_det, frame_done;
    logic [DIV_W-1:0]     cnt, cfg_div;
    logic [1:0]           cfg_par;
    logic                 cfg_stop2;
    logic [BCNT_W-1:0]    bit_cnt;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc, stop_bad;

    // Vote over the sample cycle and the two before it to reject single-cycle spikes.
    assign samp      = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
    assign fall      = rx_d1 & ~rx_s;
    assign tick      = (state == START) ? (cnt == (cfg_div >> 1)) : (cnt == cfg_div);
    assign last_data = (bit_cnt == BCNT_W'(DATA_BITS - 1));
    assign last_stop = ~cfg_stop2 | stop_idx;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        start_det  = 1'b0;
        frame_done = 1'b0;
        rx_busy    = (state != IDLE);
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (tick) state_nxt = samp ? IDLE : DATA;
            end
            DATA: begin
                if (tick && last_data) state_nxt = (^cfg_par) ? PARITY : STOP;
            end
            PARITY: begin
                if (tick) state_nxt = STOP;
            end
            STOP: begin
                if (tick && last_stop) begin
                    frame_done = 1'b1;
                    if (stop_bad | ~samp) begin
                        state_nxt = BRK;
                    end else if (fall) begin
                        // Next start edge coincides with the last stop sample.
                        state_nxt = START;
                        start_det = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            BRK: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            rx_d1         <= 1'b1;
            rx_d2         <= 1'b1;
            cnt           <= DIV_W'(1);
            bit_cnt       <= BCNT_W'(1);
            stop_idx      <= 1'b0;
            cfg_div       <= '0;
            cfg_par       <= '0;
            cfg_stop2     <= 1'b0;
            shreg         <= '0;
            par_acc       <= 1'b0;
            stop_bad      <= 1'b0;
            rx_dat        <= '0;
            rx_ok         <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_m  <= rx;
            rx_s  <= rx_m;
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;

            rx_ok         <= frame_done;
            rx_parity_err <= frame_done & (^cfg_par) & (par_acc ^ cfg_par[1]);
            rx_frame_err  <= frame_done & (stop_bad | ~samp);
            if (frame_done) rx_dat <= shreg;

            if (start_det) begin
                cfg_div   <= baud_div;
                cfg_par   <= parity_mode;
                cfg_stop2 <= stop2;
                cnt       <= '0;
            end else if (state == IDLE || state == BRK || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end

            if (tick) begin
                case (state)
                    START: begin
                        bit_cnt  <= '0;
                        par_acc  <= 1'b0;
                        stop_bad <= 1'b0;
                        stop_idx <= 1'b0;
                    end
                    DATA: begin
                        shreg   <= {samp, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ samp;
                        bit_cnt <= bit_cnt + BCNT_W'(1);
                    end
                    PARITY: par_acc <= par_acc ^ samp;
                    STOP: begin
                        stop_idx <= 1'b1;
                        stop_bad <= stop_bad | ~samp;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8-bit and 9-bit receivers on a shared line,
// each rx_ok pulse captured on the falling clock edge.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop2;

    logic [7:0]  rx_dat8;
    logic        rx_ok8, perr8, ferr8, busy8;
    logic [8:0]  rx_dat9;
    logic        rx_ok9, perr9, ferr9, busy9;

    int n_checks = 0;
    int n_errors = 0;

    int          n_ok8 = 0;
    logic [7:0]  dat8_q[$];
    logic [7:0]  dat8_last;
    logic        perr8_last, ferr8_last, busy8_at_ok;
    time         t_ok8;
    int          n_ok9 = 0;
    logic [8:0]  dat9_last;
    logic        perr9_last, ferr9_last;

    uart_rx_cfg #(.DATA_BITS(8), .DIV_W(16)) dut8 (
        .clk(clk), .rst(rst), .rx(rx), .baud_div(baud_div),
        .parity_mode(parity_mode), .stop2(stop2),
        .rx_dat(rx_dat8), .rx_ok(rx_ok8), .rx_parity_err(perr8),
        .rx_frame_err(ferr8), .rx_busy(busy8)
    );

    uart_rx_cfg #(.DATA_BITS(9), .DIV_W(16)) dut9 (
        .clk(clk), .rst(rst), .rx(rx), .baud_div(baud_div),
        .parity_mode(parity_mode), .stop2(stop2),
        .rx_dat(rx_dat9), .rx_ok(rx_ok9), .rx_parity_err(perr9),
        .rx_frame_err(ferr9), .rx_busy(busy9)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_ok8 === 1'b1) begin
            n_ok8++;
            dat8_q.push_back(rx_dat8);
            dat8_last   = rx_dat8;
            perr8_last  = perr8;
            ferr8_last  = ferr8;
            busy8_at_ok = busy8;
            t_ok8       = $time;
        end
        if (rx_ok9 === 1'b1) begin
            n_ok9++;
            dat9_last  = rx_dat9;
            perr9_last = perr9;
            ferr9_last = ferr9;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drives start bit, data LSB first, optional parity, stop bits; each bit lasts bclk clocks.
    // A one-clock inverted spike is placed spike_off clocks into line bit spike_bit.
    task automatic send_frame(input logic [8:0] data, input int nbits, input bit has_par,
                              input logic par_bit, input int nstop, input logic [1:0] stops,
                              input int bclk, input int spike_bit, input int spike_off);
        logic [15:0] v;
        int          len;
        v   = '0;
        len = 1;
        for (int i = 0; i < nbits; i++) begin v[len] = data[i]; len++; end
        if (has_par) begin v[len] = par_bit; len++; end
        for (int i = 0; i < nstop; i++) begin v[len] = stops[i]; len++; end
        for (int i = 0; i < len; i++) begin
            rx = v[i];
            if (i == spike_bit) begin
                repeat (spike_off) @(negedge clk);
                rx = ~v[i];
                @(negedge clk);
                rx = v[i];
                repeat (bclk - spike_off - 1) @(negedge clk);
            end else begin
                repeat (bclk) @(negedge clk);
            end
        end
    endtask

    task automatic expect8(input string tag, input int ok_before, input logic [7:0] dat,
                           input logic perr, input logic ferr);
        check({tag, "_okcnt"}, n_ok8 - ok_before, 1);
        check({tag, "_dat"}, dat8_last, dat);
        check({tag, "_perr"}, perr8_last, perr);
        check({tag, "_ferr"}, ferr8_last, ferr);
    endtask

    initial begin
        int  ok0;
        int  n;
        time t0;
        int  lat;

        rst = 1'b1; rx = 1'b1; baud_div = 16'd15; parity_mode = 2'b00; stop2 = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_dat", rx_dat8, 0);
        check("rst_ok", rx_ok8, 0);
        check("rst_perr", perr8, 0);
        check("rst_ferr", ferr8, 0);
        check("rst_busy", busy8, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5 with latency: 2 + 7 + 1 + 9*16 + 1 = 155 clocks
        ok0 = n_ok8; t0 = $time;
        send_frame(9'h0A5, 8, 0, 1'b0, 1, 2'b01, 16, -1, 0);
        repeat (4) @(negedge clk);
        expect8("a5", ok0, 8'hA5, 1'b0, 1'b0);
        check("a5_busy_at_ok", busy8_at_ok, 0);
        lat = int'((t_ok8 - t0) / 10);
        check("a5_latency_in_154_156", 32'(lat >= 154 && lat <= 156), 1);
        check("idle_ferr_low", ferr8, 0);

        // Spike on data bit 3 (line bit 4) landing in the sample cycle
        ok0 = n_ok8;
        send_frame(9'h0A5, 8, 0, 1'b0, 1, 2'b01, 16, 4, 8);
        repeat (4) @(negedge clk);
        expect8("spike", ok0, 8'hA5, 1'b0, 1'b0);

        // 4-clock low glitch on idle line
        ok0 = n_ok8;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", busy8, 1);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_ok", n_ok8 - ok0, 0);
        check("glitch_busy_low", busy8, 0);

        // Parity: even then odd, 0x03 has data XOR 0
        parity_mode = 2'b01;
        ok0 = n_ok8;
        send_frame(9'h003, 8, 1, 1'b1, 1, 2'b01, 16, -1, 0);
        repeat (4) @(negedge clk);
        expect8("even_p1", ok0, 8'h03, 1'b1, 1'b0);
        ok0 = n_ok8;
        send_frame(9'h003, 8, 1, 1'b0, 1, 2'b01, 16, -1, 0);
        repeat (4) @(negedge clk);
        expect8("even_p0", ok0, 8'h03, 1'b0, 1'b0);
        parity_mode = 2'b10;
        ok0 = n_ok8;
        send_frame(9'h003, 8, 1, 1'b1, 1, 2'b01, 16, -1, 0);
        repeat (4) @(negedge clk);
        expect8("odd_p1", ok0, 8'h03, 1'b0, 1'b0);
        ok0 = n_ok8;
        send_frame(9'h003, 8, 1, 1'b0, 1, 2'b01, 16, -1, 0);
        repeat (4) @(negedge clk);
        expect8("odd_p0", ok0, 8'h03, 1'b1, 1'b0);
        parity_mode = 2'b00;
        repeat (5) @(negedge clk);

        // Configuration changes mid-frame must not disturb the frame in progress
        ok0 = n_ok8;
        fork
            send_frame(9'h05A, 8, 0, 1'b0, 1, 2'b01, 16, -1, 0);
            begin
                repeat (40) @(negedge clk);
                baud_div = 16'd3; parity_mode = 2'b01; stop2 = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        expect8("cfg_latch", ok0, 8'h5A, 1'b0, 1'b0);
        baud_div = 16'd15; parity_mode = 2'b00; stop2 = 1'b0;
        repeat (5) @(negedge clk);

        // Framing error then break
        ok0 = n_ok8;
        send_frame(9'h055, 8, 0, 1'b0, 1, 2'b00, 16, -1, 0);
        repeat (4) @(negedge clk);
        expect8("brk_frame", ok0, 8'h55, 1'b0, 1'b1);
        ok0 = n_ok8;
        repeat (40) @(negedge clk);
        check("brk_no_ok", n_ok8 - ok0, 0);
        check("brk_busy", busy8, 1);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("brk_exit_busy", busy8, 0);
        ok0 = n_ok8;
        send_frame(9'h012, 8, 0, 1'b0, 1, 2'b01, 16, -1, 0);
        repeat (4) @(negedge clk);
        expect8("after_brk", ok0, 8'h12, 1'b0, 1'b0);

        // Back-to-back at baud_div = 3, no idle gap
        baud_div = 16'd3;
        ok0 = n_ok8;
        send_frame(9'h000, 8, 0, 1'b0, 1, 2'b01, 4, -1, 0);
        send_frame(9'h0FF, 8, 0, 1'b0, 1, 2'b01, 4, -1, 0);
        repeat (10) @(negedge clk);
        n = dat8_q.size();
        check("b2b_okcnt", n_ok8 - ok0, 2);
        check("b2b_first", (n >= 2) ? dat8_q[n-2] : 8'hxx, 8'h00);
        check("b2b_second", (n >= 1) ? dat8_q[n-1] : 8'hxx, 8'hFF);
        baud_div = 16'd15;
        repeat (200) @(negedge clk);

        // 9-bit, two stop bits
        stop2 = 1'b1;
        ok0 = n_ok9;
        send_frame(9'h1AB, 9, 0, 1'b0, 2, 2'b11, 16, -1, 0);
        repeat (4) @(negedge clk);
        check("nine_okcnt", n_ok9 - ok0, 1);
        check("nine_dat", dat9_last, 9'h1AB);
        check("nine_ferr", ferr9_last, 0);
        check("nine_perr", perr9_last, 0);
        ok0 = n_ok9;
        send_frame(9'h0F5, 9, 0, 1'b0, 2, 2'b01, 16, -1, 0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("nine_stop2_okcnt", n_ok9 - ok0, 1);
        check("nine_stop2_dat", dat9_last, 9'h0F5);
        check("nine_stop2_ferr", ferr9_last, 1);
        stop2 = 1'b0;
        repeat (200) @(negedge clk);

        // Reset mid-frame
        ok0 = n_ok8;
        send_frame(9'h081, 8, 0, 1'b0, 1, 2'b01, 16, -1, 0);
        repeat (4) @(negedge clk);
        expect8("pre_rst", ok0, 8'h81, 1'b0, 1'b0);
        ok0 = n_ok8;
        fork
            send_frame(9'h0FF, 8, 0, 1'b0, 1, 2'b01, 16, -1, 0);
            begin
                repeat (60) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        check("rst_mid_no_ok", n_ok8 - ok0, 0);
        check("rst_mid_dat", rx_dat8, 0);
        check("rst_mid_dat9", rx_dat9, 0);
        check("rst_mid_perr", perr8, 0);
        check("rst_mid_ferr", ferr8, 0);
        check("rst_mid_busy", busy8, 0);
        ok0 = n_ok8;
        send_frame(9'h03C, 8, 0, 1'b0, 1, 2'b01, 16, -1, 0);
        repeat (4) @(negedge clk);
        expect8("post_rst", ok0, 8'h3C, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
